// File: rtl/shram_arbiter.sv
// Round-robin arbiter for three requesters sharing one single-port
// synchronous RAM; one 3-cycle access in flight at a time.
module shram_arbiter #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iREQ0,
  input  logic          iREQ1,
  input  logic          iREQ2,
  input  logic          iWE0,
  input  logic          iWE1,
  input  logic          iWE2,
  input  logic [AW-1:0] iADR0,
  input  logic [AW-1:0] iADR1,
  input  logic [AW-1:0] iADR2,
  input  logic [DW-1:0] iWDT0,
  input  logic [DW-1:0] iWDT1,
  input  logic [DW-1:0] iWDT2,
  output logic          oACK0,
  output logic          oACK1,
  output logic          oACK2,
  output logic [DW-1:0] oRDT0,
  output logic [DW-1:0] oRDT1,
  output logic [DW-1:0] oRDT2,
  output logic [AW-1:0] oRAM_AD,
  output logic          oRAM_WE,
  output logic [DW-1:0] oRAM_WD,
  input  logic [DW-1:0] iRAM_RD,
  output logic          oBUSY
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE
  } state_t;

  state_t                 state_q;
  logic [1:0]             gnt_q;
  logic [1:0]             last_q;
  logic [2:0]             ack_q;
  logic                   wr_q;
  logic [2:0][DW-1:0]     rdt_q;
  logic [AW-1:0]          ad_q;
  logic [DW-1:0]          wd_q;
  logic                   we_q;

  logic [2:0]             elig;
  logic [1:0]             gnt_d;
  logic [AW-1:0]          adr_sel;
  logic [DW-1:0]          wdt_sel;
  logic                   we_sel;

  // A requester is masked in the cycle its ack is visible
  assign elig = {iREQ2, iREQ1, iREQ0} & ~ack_q;

  always_comb begin
    gnt_d = 2'd0;
    case (last_q)
      2'd0: gnt_d = elig[1] ? 2'd1 : (elig[2] ? 2'd2 : 2'd0);
      2'd1: gnt_d = elig[2] ? 2'd2 : (elig[0] ? 2'd0 : 2'd1);
      default: gnt_d = elig[0] ? 2'd0 : (elig[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    adr_sel = iADR0;
    wdt_sel = iWDT0;
    we_sel  = iWE0;
    case (gnt_d)
      2'd1: begin
        adr_sel = iADR1;
        wdt_sel = iWDT1;
        we_sel  = iWE1;
      end
      2'd2: begin
        adr_sel = iADR2;
        wdt_sel = iWDT2;
        we_sel  = iWE2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      state_q <= IDLE;
      gnt_q   <= 2'd0;
      last_q  <= 2'd2;
      ack_q   <= '0;
      wr_q    <= 1'b0;
      rdt_q   <= '0;
      ad_q    <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (|elig) begin
            gnt_q   <= gnt_d;
            last_q  <= gnt_d;
            ad_q    <= adr_sel;
            wd_q    <= wdt_sel;
            we_q    <= we_sel;
            wr_q    <= we_sel;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          we_q    <= 1'b0;
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          ack_q[gnt_q] <= 1'b1;
          if (!wr_q) rdt_q[gnt_q] <= iRAM_RD;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oACK0   = ack_q[0];
  assign oACK1   = ack_q[1];
  assign oACK2   = ack_q[2];
  assign oRDT0   = rdt_q[0];
  assign oRDT1   = rdt_q[1];
  assign oRDT2   = rdt_q[2];
  assign oRAM_AD = ad_q;
  assign oRAM_WE = we_q;
  assign oRAM_WD = wd_q;
  assign oBUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_shram_arbiter.sv
// Bench for shram_arbiter: timeline model of grants/acks plus a
// reference memory, compared every cycle, with directed scenarios.
module tb_shram_arbiter;

  logic        iCLK = 1'b0;
  logic        iRSTn = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  we = '0;
  logic [10:0] adr [3];
  logic [7:0]  wdt [3];
  logic [2:0]  ack;
  logic [7:0]  rdt [3];
  logic [10:0] ram_ad;
  logic        ram_we;
  logic [7:0]  ram_wd;
  logic [7:0]  ram_rd;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  logic [2:0] hold = '0;
  logic [2:0] dpend = '0;

  logic [7:0] mem [2048];
  logic [7:0] ref_mem [2048];

  always #5 iCLK = ~iCLK;

  shram_arbiter dut (
    .iCLK(iCLK), .iRSTn(iRSTn),
    .iREQ0(req[0]), .iREQ1(req[1]), .iREQ2(req[2]),
    .iWE0(we[0]), .iWE1(we[1]), .iWE2(we[2]),
    .iADR0(adr[0]), .iADR1(adr[1]), .iADR2(adr[2]),
    .iWDT0(wdt[0]), .iWDT1(wdt[1]), .iWDT2(wdt[2]),
    .oACK0(ack[0]), .oACK1(ack[1]), .oACK2(ack[2]),
    .oRDT0(rdt[0]), .oRDT1(rdt[1]), .oRDT2(rdt[2]),
    .oRAM_AD(ram_ad), .oRAM_WE(ram_we), .oRAM_WD(ram_wd),
    .iRAM_RD(ram_rd), .oBUSY(busy)
  );

  // 1-cycle synchronous RAM, not affected by reset
  always @(posedge iCLK) begin
    ram_rd <= mem[ram_ad];
    if (ram_we) mem[ram_ad] = ram_wd;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Model: an access granted at edge E drops WE at E+1 and acks at E+2
  bit         m_valid = 0;
  bit         m_busy;
  int         m_age;
  int         m_gnt;
  int         m_last;
  bit         m_is_wr;
  logic [7:0] m_rd_exp;
  logic [2:0] m_ack;
  logic [7:0] m_rdt [3];
  logic [10:0] m_ad;
  logic       m_we;
  logic [7:0] m_wd;

  always @(posedge iCLK) begin
    logic [2:0] nack;
    logic [2:0] elig;
    m_valid = 1;
    if (!iRSTn) begin
      m_busy = 0;
      m_ack = '0;
      for (int i = 0; i < 3; i++) m_rdt[i] = '0;
      m_ad = '0;
      m_we = 1'b0;
      m_wd = '0;
      m_last = 2;
    end else begin
      nack = '0;
      if (m_busy) begin
        m_age++;
        if (m_age == 1) m_we = 1'b0;
        if (m_age == 2) begin
          nack[m_gnt] = 1'b1;
          if (!m_is_wr) m_rdt[m_gnt] = m_rd_exp;
          m_busy = 0;
        end
      end else begin
        elig = req & ~m_ack;
        for (int i = 1; i <= 3; i++) begin
          int k;
          k = (m_last + i) % 3;
          if (elig[k] && !m_busy) begin
            m_busy = 1;
            m_age = 0;
            m_gnt = k;
            m_last = k;
            m_is_wr = we[k];
            m_ad = adr[k];
            m_wd = wdt[k];
            m_we = we[k];
            if (we[k]) ref_mem[adr[k]] = wdt[k];
            else m_rd_exp = ref_mem[adr[k]];
          end
        end
      end
      m_ack = nack;
    end
  end

  always @(negedge iCLK) begin
    if (m_valid) begin
      chk("ack", 32'(ack), 32'(m_ack));
      chk("rdt0", 32'(rdt[0]), 32'(m_rdt[0]));
      chk("rdt1", 32'(rdt[1]), 32'(m_rdt[1]));
      chk("rdt2", 32'(rdt[2]), 32'(m_rdt[2]));
      chk("ram_ad", 32'(ram_ad), 32'(m_ad));
      chk("ram_we", 32'(ram_we), 32'(m_we));
      chk("ram_wd", 32'(ram_wd), 32'(m_wd));
      chk("busy", 32'(busy), 32'(m_busy));
    end
  end

  // Requesters drop one cycle after their ack unless held
  task automatic tick();
    @(negedge iCLK);
    for (int k = 0; k < 3; k++) begin
      if (dpend[k]) begin
        req[k] = 1'b0;
        dpend[k] = 1'b0;
      end else if (ack[k] && !hold[k]) begin
        dpend[k] = 1'b1;
      end
    end
  endtask

  task automatic raise(int k, logic w, logic [10:0] a, logic [7:0] d);
    we[k] = w;
    adr[k] = a;
    wdt[k] = d;
    req[k] = 1'b1;
  endtask

  task automatic wait_ack(int k, int limit);
    int c;
    c = 0;
    while (!ack[k] && c < limit) begin
      tick();
      c++;
    end
    n_chk++;
    if (!ack[k]) begin
      n_err++;
      $display("FAIL wait_ack%0d: no ack in %0d cycles, required one", k, limit);
    end
  endtask

  task automatic settle();
    int c;
    c = 0;
    while ((busy || req != 0 || ack != 0) && c < 30) begin
      tick();
      c++;
    end
    n_chk++;
    if (busy || req != 0) begin
      n_err++;
      $display("FAIL settle: busy=%0b req=%0b, required idle", busy, req);
    end
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  initial begin
    int ack_at [3];
    int n0;
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end
    mem[11'h123] = 8'hA5;
    ref_mem[11'h123] = 8'hA5;
    for (int k = 0; k < 3; k++) begin
      adr[k] = '0;
      wdt[k] = '0;
    end

    // Reset values
    tick();
    tick();
    tick();
    chk("rst_ad", 32'(ram_ad), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    iRSTn = 1'b1;
    tick();

    // 1: single read
    raise(1, 1'b0, 11'h123, 8'h00);
    tick();
    chk("t1_ad_c1", 32'(ram_ad), 32'h123);
    chk("t1_busy_c1", 32'(busy), 32'h1);
    tick();
    chk("t1_busy_c2", 32'(busy), 32'h1);
    chk("t1_ack_c2", 32'(ack), 32'h0);
    tick();
    chk("t1_ack_c3", 32'(ack), 32'h2);
    chk("t1_rdt_c3", 32'(rdt[1]), 32'hA5);
    tick();
    chk("t1_ack_c4", 32'(ack), 32'h0);
    settle();

    // 2: write then read-back
    raise(0, 1'b1, 11'h7FF, 8'h3C);
    tick();
    chk("t2_we_c1", 32'(ram_we), 32'h1);
    chk("t2_wd_c1", 32'(ram_wd), 32'h3C);
    tick();
    chk("t2_we_c2", 32'(ram_we), 32'h0);
    tick();
    chk("t2_ack_c3", 32'(ack), 32'h1);
    chk("t2_rdt0", 32'(rdt[0]), 32'h0);
    settle();
    raise(2, 1'b0, 11'h7FF, 8'h00);
    wait_ack(2, 8);
    chk("t2_rdt2", 32'(rdt[2]), 32'h3C);
    settle();

    // 3: contention from reset release
    iRSTn = 1'b0;
    tick();
    tick();
    raise(0, 1'b0, 11'h001, 8'h00);
    raise(1, 1'b0, 11'h002, 8'h00);
    raise(2, 1'b0, 11'h003, 8'h00);
    iRSTn = 1'b1;
    for (int k = 0; k < 3; k++) ack_at[k] = -1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      for (int k = 0; k < 3; k++)
        if (ack[k] && ack_at[k] < 0) ack_at[k] = c;
    end
    chk("t3_ack0_cyc", 32'(ack_at[0]), 32'd3);
    chk("t3_ack1_cyc", 32'(ack_at[1]), 32'd6);
    chk("t3_ack2_cyc", 32'(ack_at[2]), 32'd9);
    chk("t3_rdt2", 32'(rdt[2]), 32'h59);
    settle();

    // 4: fairness against a persistent requester 0
    hold[0] = 1'b1;
    raise(0, 1'b0, 11'h010, 8'h00);
    tick();
    tick();
    raise(2, 1'b0, 11'h020, 8'h00);
    n0 = 0;
    for (int c = 0; c < 12 && !ack[2]; c++) begin
      tick();
      if (ack[0]) n0++;
    end
    chk("t4_ack2_seen", 32'(ack[2]), 32'h1);
    chk("t4_acc_before", 32'(n0 <= 1), 32'h1);
    chk("t4_rdt2", 32'(rdt[2]), 32'h7A);
    hold[0] = 1'b0;
    req[0] = 1'b0;
    settle();

    // 5: ack masking, no second grant
    raise(1, 1'b0, 11'h030, 8'h00);
    wait_ack(1, 8);
    n0 = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ack[1] || busy) n0++;
    end
    chk("t5_regrant", 32'(n0), 32'd0);
    settle();

    // 6a: reset during CAPTURE of a read
    raise(1, 1'b0, 11'h055, 8'h00);
    tick();
    tick();
    chk("t6_busy_c2", 32'(busy), 32'h1);
    iRSTn = 1'b0;
    tick();
    chk("t6_ack_rst", 32'(ack), 32'h0);
    chk("t6_rdt1_rst", 32'(rdt[1]), 32'h0);
    chk("t6_busy_rst", 32'(busy), 32'h0);
    iRSTn = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_ack_again", 32'(ack), 32'h2);
    chk("t6_rdt1", 32'(rdt[1]), 32'h0F);
    settle();

    // 6b: reset coinciding with the ACCESS of a write
    raise(0, 1'b1, 11'h200, 8'h77);
    tick();
    chk("t6b_we_c1", 32'(ram_we), 32'h1);
    iRSTn = 1'b0;
    req[0] = 1'b0;
    tick();
    chk("t6b_busy", 32'(busy), 32'h0);
    chk("t6b_ack", 32'(ack), 32'h0);
    iRSTn = 1'b1;
    settle();
    raise(2, 1'b0, 11'h200, 8'h00);
    wait_ack(2, 8);
    chk("t6b_rdt2", 32'(rdt[2]), 32'h77);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/shram_arbiter.md
Name: shram_arbiter

Overview:
Arbitrates three CPU-side requesters (main, sub, sound) onto one single-port synchronous shared RAM.
Round-robin fair grant.
Returns registered per-requester read data and a one-cycle acknowledge. These feed the read-data selectors downstream as data/select pairs: oRDTk is the data, and oACKk or the owner's chip-select is the select.
One access takes 3 cycles; one access is in flight at a time.

Parameters:
AW, 11, RAM address width (2 KB shared RAM)
DW, 8, data width

Ports:
iCLK  in  1  system clock; all logic on rising edge
iRSTn  in  1  synchronous reset, active-low
iREQ0/iREQ1/iREQ2  in  1 each  access request; level, held until matching oACKk seen
iWE0/iWE1/iWE2  in  1 each  1 = write, 0 = read; stable while iREQk high
iADR0/iADR1/iADR2  in  AW each  address; stable while iREQk high
iWDT0/iWDT1/iWDT2  in  DW each  write data; stable while iREQk high
oACK0/oACK1/oACK2  out  1 each  access complete, one-cycle pulse
oRDT0/oRDT1/oRDT2  out  DW each  last read data for requester k; held between reads
oRAM_AD  out  AW  RAM address, registered
oRAM_WE  out  1  RAM write enable, registered
oRAM_WD  out  DW  RAM write data, registered
iRAM_RD  in  DW  RAM read data; valid in the cycle after oRAM_AD is presented (1-cycle synchronous RAM)
oBUSY  out  1  1 when state is not IDLE

Behaviour:
- Reset values (iRSTn=0 at an edge): state IDLE, all oACKk=0, all oRDTk=0, oRAM_AD=0, oRAM_WE=0, oRAM_WD=0, oBUSY=0, round-robin pointer LAST=2 (so requester 0 has top priority first).
- FSM has three states: IDLE → ACCESS → CAPTURE → IDLE. No other transitions.
- IDLE:
  - Eligible requesters are those with iREQk=1 AND oACKk=0. The acked requester is masked in the cycle its ack is visible.
  - If none are eligible, stay in IDLE.
  - Otherwise grant the first eligible requester in order LAST+1, LAST+2, LAST+3 (mod 3).
  - On that edge: GNT=k, LAST=k, oRAM_AD=iADRk, oRAM_WD=iWDTk, oRAM_WE=iWEk; go to ACCESS.
- ACCESS: the RAM samples oRAM_AD/oRAM_WE/oRAM_WD on this cycle's closing edge. On that edge oRAM_WE←0; go to CAPTURE.
- CAPTURE: on the closing edge:
  - oACK[GNT]←1.
  - If the access was a read, oRDT[GNT]←iRAM_RD. A write leaves oRDT[GNT] unchanged.
  - Go to IDLE.
- oACKk is high for exactly one cycle: it clears on the next edge unconditionally.
- Latency: request sampled in IDLE cycle C0; RAM address on the bus in C1; data captured at the end of C2; oACKk=1 and oRDTk valid in C3.
- Back-to-back: a new grant can be made in C3, so sustained throughput is one access per 3 cycles.
- Simultaneous requests are served round-robin. With all three requesting continuously the order is 0,1,2,0,…, and no requester waits more than 2 accesses.
- oRAM_AD and oRAM_WD hold their value after an access until the next grant.
- Only one oACKk is ever high in a given cycle.
- Reset mid-operation:
  - A synchronous reset in any state returns everything to its reset values on that edge; no ack is issued.
  - A write whose ACCESS cycle coincides with reset is still committed, because the RAM samples oRAM_WE=1 on the same edge.
- Requester protocol violations (changing iADR/iWE/iWDT while iREQ is high) are not handled. The values sampled at the grant edge are used.

Test Plan:
1. Single read:
   - Stimulus: preload RAM[0x123]=0xA5; raise iREQ1 with iWE1=0, iADR1=0x123 in C0.
   - Required: oRAM_AD=0x123 in C1; oACK1=1 with oRDT1=0xA5 in C3 only; oBUSY=1 in C1–C2.
2. Write then read-back:
   - Stimulus: requester 0 writes 0x3C to 0x7FF.
   - Required: oRAM_WE=1 for exactly one cycle (C1); a later requester 2 read of 0x7FF returns oRDT2=0x3C; oRDT0 unchanged by the write.
3. Contention:
   - Stimulus: iREQ0/1/2 all asserted from reset release, each dropping one cycle after its ack.
   - Required: grant order 0,1,2; acks in cycles C3, C6, C9.
4. Fairness:
   - Stimulus: iREQ0 held permanently (re-raised immediately after each ack) while iREQ2 is raised once.
   - Required: requester 2 is acked no later than the second access after it is raised.
5. Ack masking:
   - Stimulus: requester holds iREQ high through its ack cycle, then drops it.
   - Required: no second grant to that requester.
6. Reset mid-access:
   - Stimulus: pull iRSTn low during CAPTURE of a read.
   - Required: no oACK; oRDTk=0; state IDLE; the same request is re-served normally after release.
